// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg
//   Shared definitions for the instruction-fetch / next-PC stage.
//   - DEF_* : default values for the stage parameters
//   - fetch_state_e : stage FSM states (BOOT, RUN)
//   - fb_entry_t : one fetch-buffer entry {instr, pc4} at the default widths
package if_fetch_pkg;

  localparam int unsigned DEF_PC_W     = 10;
  localparam int unsigned DEF_INSTR_W  = 32;
  localparam int unsigned DEF_PC_STEP  = 4;
  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_FB_DEPTH = 2;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    pc4;
  } fb_entry_t;

endpackage

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer
//   Small synchronous FIFO holding fetched {instr, pc4} entries for decode.
//   Head is read combinationally so a pushed entry is visible the cycle
//   after the push. When empty, the head outputs hold the last head seen.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   push, push_data  : write one entry (ignored when full or flushing)
//   pop              : remove head entry (ignored when empty)
//   flush            : discard all entries at the clock edge (after pop)
//   occupancy        : number of stored entries
//   empty            : occupancy == 0
//   head_data        : current head entry (last head when empty)
module if_fetch_buffer
  import if_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_INSTR_W + DEF_PC_W,
  parameter int unsigned DEPTH  = DEF_FB_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [AW:0]       occupancy,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] last_head_q, last_head_d;
  logic              push_ok, pop_ok;

  assign empty     = (count_q == '0);
  assign occupancy = count_q;
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & ~flush & (count_q != (AW+1)'(DEPTH));
  assign head_data = empty ? last_head_q : mem[rd_ptr_q];

  always_comb begin
    rd_ptr_d    = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d    = wr_ptr_q + AW'(push_ok);
    count_d     = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    last_head_d = empty ? last_head_q : mem[rd_ptr_q];
    if (flush) begin
      // Pointers realign on the post-pop read pointer so the storage
      // slot order keeps rotating naturally.
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_head_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_head_q <= last_head_d;
    end
  end

  // Storage needs no reset: it is only read while count_q is non-zero.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/if_fetch_npc_stage.sv
// if_fetch_npc_stage
//   Instruction-fetch stage sitting in front of the PC register. Produces
//   the next PC every cycle, issues instruction-memory reads at pc_in,
//   buffers returned instructions with their PC+step and hands them to
//   decode over a valid/ready handshake. Redirects flush buffered and
//   in-flight fetches.
// Optional feature macro: IF_FETCH_PERF_CNT_EN (adds perf_fetched and
//   perf_redirects saturating 16-bit counters).
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   pc_in / npc_out          : PC register output / next value it loads
//   imem_req/addr/gnt        : read request, address (= pc_in), same-cycle grant
//   imem_rvalid/rdata        : read data, one cycle after a grant
//   redirect_valid/target    : taken branch/jump pulse and destination
//   id_valid/ready/instr/pc4 : fetch-buffer head towards decode
module if_fetch_npc_stage
  import if_fetch_pkg::*;
#(
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned INSTR_W  = DEF_INSTR_W,
  parameter int unsigned PC_STEP  = DEF_PC_STEP,
  parameter int unsigned RESET_PC = DEF_RESET_PC,
  parameter int unsigned FB_DEPTH = DEF_FB_DEPTH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PC_W-1:0]    pc_in,
  output logic [PC_W-1:0]    npc_out,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc4
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_redirects
`endif
);

  localparam int unsigned AW      = $clog2(FB_DEPTH);
  localparam int unsigned ENTRY_W = INSTR_W + PC_W;

  fetch_state_e state_q, state_d;

  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            drop_q, drop_d;

  logic [AW:0]        occupancy;
  logic               fb_empty;
  logic [ENTRY_W-1:0] head_data;
  logic [ENTRY_W-1:0] push_data;
  logic               push, pop, grant, redirect_fire, credit_ok;
  logic [AW+1:0]      demand, supply;

  assign imem_addr = pc_in;

  assign id_valid = (state_q == RUN) & ~fb_empty;
  assign pop      = id_valid & id_ready;
  assign id_instr = head_data[ENTRY_W-1:PC_W];
  assign id_pc4   = head_data[PC_W-1:0];

  // Credit check: occupancy + inflight - pop < FB_DEPTH, rearranged so no
  // subtraction can underflow.
  assign demand    = {1'b0, occupancy} + (AW+2)'(inflight_q);
  assign supply    = (AW+2)'(FB_DEPTH) + (AW+2)'(pop);
  assign credit_ok = (demand < supply);

  // FSM and next-PC mux
  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    redirect_fire = 1'b0;
    npc_out       = PC_W'(RESET_PC);
    case (state_q)
      BOOT: begin
        // PC register has no reset; this cycle loads RESET_PC into it.
        state_d = RUN;
      end
      RUN: begin
        redirect_fire = redirect_valid;
        imem_req      = ~redirect_valid & credit_ok;
        if (redirect_valid) begin
          npc_out = redirect_target;
        end else if (imem_req & imem_gnt) begin
          npc_out = pc_in + PC_W'(PC_STEP);
        end else begin
          npc_out = pc_in;
        end
      end
    endcase
  end

  assign grant = imem_req & imem_gnt;

  // A response is kept only if it belongs to a live request and no
  // redirect arrives alongside it.
  assign push      = imem_rvalid & inflight_q & ~drop_q & ~redirect_fire;
  assign push_data = {imem_rdata, inflight_pc_q + PC_W'(PC_STEP)};

  // In-flight / drop tracking
  always_comb begin
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = drop_q;
    if (imem_rvalid) begin
      inflight_d = 1'b0;
      drop_d     = 1'b0;
    end else if (redirect_fire && inflight_q) begin
      drop_d = 1'b1;
    end
    // A new grant can coincide with the previous response (back-to-back).
    if (grant) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_in;
      drop_d        = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= BOOT;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
    end
  end

  if_fetch_buffer #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FB_DEPTH)
  ) u_fetch_buffer (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_fire),
    .occupancy (occupancy),
    .empty     (fb_empty),
    .head_data (head_data)
  );

`ifdef IF_FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q;
    perf_redirects_d = perf_redirects_q;
    if (push && (perf_fetched_q != 16'hFFFF)) begin
      perf_fetched_d = perf_fetched_q + 16'd1;
    end
    if (redirect_fire && (perf_redirects_q != 16'hFFFF)) begin
      perf_redirects_d = perf_redirects_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_if_fetch_npc_stage.sv
// tb_if_fetch_npc_stage
//   Drives the fetch stage with a PC register and an instruction memory
//   modelled in the bench, and compares every cycle against a queue-based
//   model of the fetch stream (expected PC, request, head of buffer).
module tb_if_fetch_npc_stage;
  import if_fetch_pkg::*;

  localparam int PC_W     = 10;
  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;
  localparam int RESET_PC = 0;
  localparam int FB_DEPTH = 2;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [PC_W-1:0]    pc_in;
  logic [PC_W-1:0]    npc_out;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_target;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc4;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [15:0]        perf_fetched;
  logic [15:0]        perf_redirects;
`endif

  always #5 clock = ~clock;

  // External PC register: no reset, loads npc_out every edge.
  always @(posedge clock) pc_in <= npc_out;

  if_fetch_npc_stage dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pc_in           (pc_in),
    .npc_out         (npc_out),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc4          (id_pc4)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_redirects  (perf_redirects)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] instr_of(input logic [PC_W-1:0] a);
    return 32'hC0DE_0000 ^ {a, 22'h15A5A} ^ {22'd0, a};
  endfunction

  function automatic logic [PC_W-1:0] pc_plus(input logic [PC_W-1:0] a);
    return PC_W'((32'(a) + PC_STEP) % (1 << PC_W));
  endfunction

  // Reference model state
  fb_entry_t       mq[$];
  bit              m_boot;
  bit              pend;
  logic [PC_W-1:0] pend_pc;
  logic [PC_W-1:0] m_pc;
  int              m_pushes;
  int              m_redirs;
  // Instruction memory: response one cycle after a granted request
  bit              mem_next;
  logic [PC_W-1:0] mem_next_addr;

  task automatic model_reset();
    mq.delete();
    m_boot   = 1'b1;
    pend     = 1'b0;
    pend_pc  = '0;
    m_pc     = '0;
    m_pushes = 0;
    m_redirs = 0;
    mem_next = 1'b0;
  endtask

  task automatic step(input bit rdir, input logic [PC_W-1:0] tgt, input bit gnt, input bit rdy);
    logic [PC_W-1:0] e_npc;
    bit              e_req;
    bit              pop_m;
    int              occ;
    fb_entry_t       ent;
    @(negedge clock);
    redirect_valid  = rdir;
    redirect_target = tgt;
    imem_gnt        = gnt;
    id_ready        = rdy;
    imem_rvalid     = mem_next;
    imem_rdata      = mem_next ? instr_of(mem_next_addr) : 32'hDEAD_BEEF;
    #1;
    occ = mq.size();
    if (m_boot) begin
      e_npc = PC_W'(RESET_PC);
      e_req = 1'b0;
      pop_m = 1'b0;
      occ   = 0;
    end else begin
      pop_m = (occ > 0) && rdy;
      e_req = !rdir && ((occ + int'(pend) - int'(pop_m)) < FB_DEPTH);
      if (rdir)               e_npc = tgt;
      else if (e_req && gnt)  e_npc = pc_plus(m_pc);
      else                    e_npc = m_pc;
      check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
    end
    check_eq("npc_out", 32'(npc_out), 32'(e_npc));
    check_eq("imem_req", 32'(imem_req), 32'(e_req));
    check_eq("id_valid", 32'(id_valid), 32'(occ > 0));
    if (occ > 0) begin
      check_eq("id_instr", id_instr, mq[0].instr);
      check_eq("id_pc4", 32'(id_pc4), 32'(mq[0].pc4));
    end
    // Memory answers the handshake the DUT actually made
    mem_next      = imem_req && gnt;
    mem_next_addr = imem_addr;
    // Model update for this clock edge
    if (pop_m) begin
      $display("decode pc4=0x%03h instr=0x%08h", mq[0].pc4, mq[0].instr);
      void'(mq.pop_front());
    end
    if (!m_boot && pend && !rdir) begin
      ent.instr = instr_of(pend_pc);
      ent.pc4   = pc_plus(pend_pc);
      mq.push_back(ent);
      m_pushes++;
    end
    if (!m_boot && rdir) begin
      mq.delete();
      m_redirs++;
    end
    pend    = !m_boot && e_req && gnt;
    pend_pc = m_pc;
    m_pc    = e_npc;
    m_boot  = 1'b0;
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step(($urandom % 20) == 0, PC_W'($urandom) & 10'h3FC,
           ($urandom % 4) != 0, ($urandom % 10) < 7);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    pc_in           = 10'h155;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    id_ready        = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check_eq("rst_npc", 32'(npc_out), 32'(RESET_PC));
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(id_valid), 32'd0);
    check_eq("rst_instr", id_instr, 32'd0);
    check_eq("rst_pc4", 32'(id_pc4), 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;

    // BOOT cycle, then streaming at full rate
    step(1'b0, '0, 1'b1, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // Backpressure then resume
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);

    // Grant denied at 0x010
    step(1'b1, 10'h010, 1'b1, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);

    // Redirect with buffered entry and one response arriving
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 10'h120, 1'b1, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1, 1'b1);

    // Wrap past 0x3FC
    step(1'b1, 10'h3F8, 1'b1, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // Randomized traffic
    rand_steps(600);

`ifdef IF_FETCH_PERF_CNT_EN
    @(negedge clock);
    #1;
    check_eq("perf_fetched", 32'(perf_fetched), 32'(m_pushes));
    check_eq("perf_redirects", 32'(perf_redirects), 32'(m_redirs));
`endif

    // Asynchronous reset mid-stream, away from the clock edges
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(id_valid), 32'd0);
    check_eq("arst_req", 32'(imem_req), 32'd0);
    check_eq("arst_npc", 32'(npc_out), 32'(RESET_PC));
    model_reset();
    imem_rvalid = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b1);
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);
    rand_steps(150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_npc_stage.md
Name: if_fetch_npc_stage

Overview:
- Instruction-fetch stage directly upstream of the PC register.
- Computes the next-PC value the PC register loads every clock. Issues instruction-memory reads at the current PC.
- Buffers returned instructions, with their PC+step, in a small FIFO feeding decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

Parameters:
PC_W, 10, PC/address width; all PC arithmetic is modulo 2^PC_W
INSTR_W, 32, instruction width
PC_STEP, 4, PC increment per fetched instruction (byte-addressed)
RESET_PC, 0, first PC fetched after reset
FB_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
pc_in  in  PC_W  current PC from PC register output
npc_out  out  PC_W  next PC, loaded by PC register at every clock edge
imem_req  out  1  read request
imem_addr  out  PC_W  read address, = pc_in
imem_gnt  in  1  same-cycle grant of imem_req
imem_rvalid  in  1  read data valid, exactly 1 cycle after a granted request
imem_rdata  in  INSTR_W  read data
redirect_valid  in  1  one-cycle redirect pulse (taken branch/jump)
redirect_target  in  PC_W  redirect destination
id_valid  out  1  buffer head valid to decode
id_ready  in  1  decode accepts head
id_instr  out  INSTR_W  head instruction
id_pc4  out  PC_W  head PC + PC_STEP

Behaviour:
- Clock/reset: one clock, `clock`. Reset is asynchronous and active-low on `reset_n`; it clears FSM, FIFO, in-flight flag and counters immediately.
- The PC register has no reset of its own. This block steers it through the BOOT state.
- FSM states: BOOT, RUN.
  - BOOT is the reset state. npc_out=RESET_PC, imem_req=0, id_valid=0.
  - BOOT -> RUN unconditionally on the first clock after reset release. The PC register then holds RESET_PC.
- RUN, issue rule: imem_req=1 when no redirect this cycle AND (occupancy + inflight - pop) < FB_DEPTH.
  - pop = id_valid & id_ready.
  - inflight = 1 if a granted request awaits its rvalid.
- Next-PC priority in RUN:
  1. redirect_valid: npc_out=redirect_target.
  2. imem_req & imem_gnt: npc_out=pc_in+PC_STEP, wrapping modulo 2^PC_W (0x3FC+4 -> 0x000).
  3. Otherwise npc_out=pc_in (PC holds).
- In-flight tracking: on grant, latch pc_in into an in-flight PC register and set inflight. On imem_rvalid, push {imem_rdata, inflight_pc+PC_STEP} into the FIFO and clear inflight.
- Redirect, same cycle:
  - FIFO flushed at the clock edge; a simultaneous pop is still honoured for the current head.
  - Any in-flight response is marked drop and discarded when it arrives, with no push.
  - No request is issued.
  - Fetch from the target starts the following cycle.
- Redirect arriving in the same cycle as imem_rvalid: that data is discarded.
- Full FIFO: no issue, PC holds. Issue resumes the cycle a pop frees a credit; a pop in the same cycle counts.
- Empty FIFO: id_valid=0; id_instr/id_pc4 are don't-care but stable (last head).
- Simultaneous push and pop on a full FIFO is not possible by the credit rule. On a non-empty FIFO both occur in one cycle and occupancy is unchanged.
- Latency: a granted request at cycle N gives id_valid at N+2 if the FIFO was empty. Sustained throughput is 1 instruction/cycle with FB_DEPTH>=2 and decode always ready.
- Reset values: npc_out=RESET_PC, imem_req=0, imem_addr=pc_in (pass-through), id_valid=0, id_instr=0, id_pc4=0.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[15:0] and perf_redirects[15:0].
  - perf_fetched counts pushes; perf_redirects counts redirect_valid cycles in RUN.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: ports and logic absent; no other behaviour changes.

Decomposition:
- Package if_fetch_pkg holds PC_W, INSTR_W, PC_STEP and RESET_PC defaults, the FSM state enum {BOOT, RUN}, and the FIFO entry struct {instr, pc4}.
- Sub-module if_fetch_buffer: synchronous FIFO with push, pop, flush, occupancy, and head outputs.
- Top holds FSM, credit/issue logic, in-flight/drop tracking and npc mux.

Test Plan:
- Reset release with pc_in driven from a PC register model: npc_out=0x000 in BOOT. First request addr=0x000; then 0x004, 0x008 on consecutive cycles with gnt=1 and id_ready=1. id_pc4 sequence 0x004, 0x008...
- Backpressure: id_ready=0 after 2 pushes. imem_req drops, npc_out==pc_in and holds. Raising id_ready resumes the fetch at the next PC with no loss or duplication.
- Grant denied: imem_gnt=0 for 3 cycles at pc=0x010. PC holds 0x010, then advances to 0x014 on grant.
- Redirect with full FIFO and one in-flight: redirect_target=0x120. FIFO empties, the arriving rvalid data is dropped, next request addr=0x120, first id_pc4=0x124.
- Wrap: pc=0x3FC granted. npc_out=0x000, id_pc4=0x000.
- Async reset_n asserted mid-stream, not clock-aligned: id_valid=0 immediately. After release, BOOT again and fetch restarts at RESET_PC.
